// File: rtl/interp_pkg.sv
// Shared types and constants for the 10x interpolator output path.
package interp_pkg;

  localparam int unsigned INTERP_RATIO = 10;
  localparam int unsigned SAMPLE_W     = 8;
  localparam int unsigned IDX_W        = 4;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [IDX_W-1:0]    idx_t;

  localparam sample_t IDLE_SAMPLE = 8'h80;

endpackage

// File: rtl/interp_hold_buffer_10x.sv
// Hold half of the hold/play double buffer: captures the ten parallel samples
// on end_stage and tracks whether an unplayed set is waiting.
module interp_hold_buffer_10x
  import interp_pkg::*;
#(
  parameter int unsigned WIDTH = SAMPLE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_i,
  input  logic             capture_i,
  input  logic             transfer_i,
  input  logic [WIDTH-1:0] sample_i [INTERP_RATIO],
  output logic [WIDTH-1:0] hold_o   [INTERP_RATIO],
  output logic             hold_valid_o
);

  logic [WIDTH-1:0] hold_q [INTERP_RATIO];
  logic [WIDTH-1:0] hold_d [INTERP_RATIO];
  logic             hold_valid_q;
  logic             hold_valid_d;

  // Capture wins over transfer: a same-tick capture keeps hold_valid set.
  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (tick_i) begin
      if (capture_i) begin
        hold_d       = sample_i;
        hold_valid_d = 1'b1;
      end else if (transfer_i) begin
        hold_valid_d = 1'b0;
      end
    end
  end

  // Sample bank carries no reset; only the valid flag does.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
    if (reset) hold_valid_q <= 1'b0;
    else       hold_valid_q <= hold_valid_d;
  end

  assign hold_o       = hold_q;
  assign hold_valid_o = hold_valid_q;

endmodule

// File: rtl/interp_serializer_10x.sv
// Replays the ten captured interpolator samples one per clk_en_10x tick
// during the base period after capture, with underrun/overrun reporting.
module interp_serializer_10x
  import interp_pkg::*;
#(
  parameter int unsigned      WIDTH      = SAMPLE_W,
  parameter logic [WIDTH-1:0] IDLE_VALUE = WIDTH'(IDLE_SAMPLE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             clk_en_10x,
  input  logic             end_stage,
  input  logic [WIDTH-1:0] sample_y0,
  input  logic [WIDTH-1:0] sample_y1,
  input  logic [WIDTH-1:0] sample_y2,
  input  logic [WIDTH-1:0] sample_y3,
  input  logic [WIDTH-1:0] sample_y4,
  input  logic [WIDTH-1:0] sample_y5,
  input  logic [WIDTH-1:0] sample_y6,
  input  logic [WIDTH-1:0] sample_y7,
  input  logic [WIDTH-1:0] sample_y8,
  input  logic [WIDTH-1:0] sample_y9,
  output logic [WIDTH-1:0] sample_out,
  output logic             sample_valid,
  output logic             underrun,
  output logic             overrun
);

  logic             tick_c;
  logic             period_start_c;
  logic [WIDTH-1:0] sample_in_c [INTERP_RATIO];
  logic [WIDTH-1:0] hold_c      [INTERP_RATIO];
  logic             hold_valid_c;

  logic [WIDTH-1:0] play_q [INTERP_RATIO];
  logic [WIDTH-1:0] play_d [INTERP_RATIO];
  idx_t             idx_q, idx_d;
  logic             playing_q, playing_d;
  logic [WIDTH-1:0] sample_out_q, sample_out_d;
  logic             sample_valid_q, sample_valid_d;
  logic             underrun_q, underrun_d;
  logic             overrun_q, overrun_d;

  assign tick_c         = clk_en_10x;
  assign period_start_c = clk_en_10x & clk_en;

  assign sample_in_c[0] = sample_y0;
  assign sample_in_c[1] = sample_y1;
  assign sample_in_c[2] = sample_y2;
  assign sample_in_c[3] = sample_y3;
  assign sample_in_c[4] = sample_y4;
  assign sample_in_c[5] = sample_y5;
  assign sample_in_c[6] = sample_y6;
  assign sample_in_c[7] = sample_y7;
  assign sample_in_c[8] = sample_y8;
  assign sample_in_c[9] = sample_y9;

  interp_hold_buffer_10x #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk          (clk),
    .reset        (reset),
    .tick_i       (tick_c),
    .capture_i    (end_stage),
    .transfer_i   (period_start_c),
    .sample_i     (sample_in_c),
    .hold_o       (hold_c),
    .hold_valid_o (hold_valid_c)
  );

  // Play-side sequencing: load at period start, step per tick, flag exhaustion.
  always_comb begin
    play_d         = play_q;
    idx_d          = idx_q;
    playing_d      = playing_q;
    sample_out_d   = sample_out_q;
    sample_valid_d = sample_valid_q;
    underrun_d     = 1'b0;
    overrun_d      = 1'b0;
    if (tick_c) begin
      if (period_start_c) begin
        if (hold_valid_c) begin
          play_d         = hold_c;
          sample_out_d   = hold_c[0];
          idx_d          = idx_t'(1);
          playing_d      = 1'b1;
          sample_valid_d = 1'b1;
        end else begin
          sample_out_d   = IDLE_VALUE;
          sample_valid_d = 1'b0;
          playing_d      = 1'b0;
          idx_d          = '0;
          underrun_d     = 1'b1;
        end
      end else if (playing_q) begin
        if (idx_q == idx_t'(INTERP_RATIO)) begin
          sample_out_d   = IDLE_VALUE;
          sample_valid_d = 1'b0;
          playing_d      = 1'b0;
          overrun_d      = 1'b1;
        end else begin
          sample_out_d = play_q[idx_q];
          idx_d        = idx_q + idx_t'(1);
        end
      end else begin
        sample_out_d   = IDLE_VALUE;
        sample_valid_d = 1'b0;
      end
    end
  end

  // Play buffer is data-only; control and outputs reset to idle.
  always_ff @(posedge clk) begin
    play_q <= play_d;
    if (reset) begin
      idx_q          <= '0;
      playing_q      <= 1'b0;
      sample_out_q   <= IDLE_VALUE;
      sample_valid_q <= 1'b0;
      underrun_q     <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      idx_q          <= idx_d;
      playing_q      <= playing_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      underrun_q     <= underrun_d;
      overrun_q      <= overrun_d;
    end
  end

  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign underrun     = underrun_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_interp_serializer_10x.sv
// Self-checking bench for interp_serializer_10x: queue-based reference model,
// per-cycle comparison, directed scenarios plus randomized tick streams.
module tb_interp_serializer_10x;

  localparam logic [7:0] IDLE = 8'h80;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clk_en = 1'b0;
  logic       clk_en_10x = 1'b0;
  logic       end_stage = 1'b0;
  logic [7:0] ys [10];
  logic [7:0] sample_out;
  logic       sample_valid;
  logic       underrun;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  interp_serializer_10x dut (
    .clk          (clk),
    .reset        (reset),
    .clk_en       (clk_en),
    .clk_en_10x   (clk_en_10x),
    .end_stage    (end_stage),
    .sample_y0    (ys[0]),
    .sample_y1    (ys[1]),
    .sample_y2    (ys[2]),
    .sample_y3    (ys[3]),
    .sample_y4    (ys[4]),
    .sample_y5    (ys[5]),
    .sample_y6    (ys[6]),
    .sample_y7    (ys[7]),
    .sample_y8    (ys[8]),
    .sample_y9    (ys[9]),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .underrun     (underrun),
    .overrun      (overrun)
  );

  // Reference model: a pending captured set and a FIFO of samples left to play.
  logic [7:0] m_hold [10];
  bit         m_hold_valid = 1'b0;
  bit         m_playing    = 1'b0;
  logic [7:0] m_fifo [$];
  logic [7:0] exp_out   = IDLE;
  logic       exp_valid = 1'b0;
  logic       exp_under = 1'b0;
  logic       exp_over  = 1'b0;

  always @(posedge clk) begin
    exp_under = 1'b0;
    exp_over  = 1'b0;
    if (reset) begin
      m_hold_valid = 1'b0;
      m_playing    = 1'b0;
      m_fifo.delete();
      exp_out   = IDLE;
      exp_valid = 1'b0;
    end else if (clk_en_10x) begin
      if (clk_en) begin
        m_fifo.delete();
        if (m_hold_valid) begin
          for (int k = 0; k < 10; k++) m_fifo.push_back(m_hold[k]);
          exp_out   = m_fifo.pop_front();
          exp_valid = 1'b1;
          m_playing = 1'b1;
        end else begin
          exp_out   = IDLE;
          exp_valid = 1'b0;
          m_playing = 1'b0;
          exp_under = 1'b1;
        end
        m_hold_valid = end_stage;
      end else if (m_playing) begin
        if (m_fifo.size() > 0) begin
          exp_out = m_fifo.pop_front();
        end else begin
          exp_out   = IDLE;
          exp_valid = 1'b0;
          m_playing = 1'b0;
          exp_over  = 1'b1;
        end
      end else begin
        exp_out   = IDLE;
        exp_valid = 1'b0;
      end
      if (end_stage) begin
        for (int k = 0; k < 10; k++) m_hold[k] = ys[k];
        m_hold_valid = 1'b1;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, got, want);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("sample_out",   32'(sample_out),   32'(exp_out));
      check("sample_valid", 32'(sample_valid), 32'(exp_valid));
      check("underrun",     32'(underrun),     32'(exp_under));
      check("overrun",      32'(overrun),      32'(exp_over));
    end
  end

  task automatic set_samples(input logic [7:0] base, input bit rnd);
    for (int k = 0; k < 10; k++) ys[k] = rnd ? 8'($urandom) : base + 8'(k);
  endtask

  // Random idle gap (clk_en/end_stage noise must be ignored), then one tick.
  task automatic do_tick(input bit ce, input bit es, input logic [7:0] base, input bit rnd);
    int gap;
    gap = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) begin
      clk_en     = 1'($urandom);
      end_stage  = 1'($urandom);
      clk_en_10x = 1'b0;
      @(negedge clk);
    end
    clk_en     = ce;
    end_stage  = es;
    clk_en_10x = 1'b1;
    if (es) set_samples(base, rnd);
    @(negedge clk);
    clk_en     = 1'b0;
    end_stage  = 1'b0;
    clk_en_10x = 1'b0;
  endtask

  task automatic do_reset();
    clk_en     = 1'b0;
    end_stage  = 1'b0;
    clk_en_10x = 1'b0;
    reset      = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    set_samples(8'h00, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_out",   32'(sample_out),   32'h80);
    check("rst_valid", 32'(sample_valid), 32'h0);

    // Period start with nothing captured.
    do_tick(1'b1, 1'b0, 8'h00, 1'b0);
    check("t1_out",   32'(sample_out), 32'h80);
    check("t1_under", 32'(underrun),   32'h1);

    // Capture 10..19, play it; capture 20..29 on tick 9 of that period.
    do_tick(1'b0, 1'b1, 8'h10, 1'b0);
    do_tick(1'b1, 1'b0, 8'h00, 1'b0);
    check("t2_y0",    32'(sample_out),   32'h10);
    check("t2_valid", 32'(sample_valid), 32'h1);
    for (int t = 1; t < 10; t++) begin
      do_tick(1'b0, t == 8, 8'h20, 1'b0);
      check("t2_yk", 32'(sample_out), 32'h10 + 32'(t));
    end
    do_tick(1'b1, 1'b0, 8'h00, 1'b0);
    check("t3_y0", 32'(sample_out), 32'h20);
    for (int t = 1; t < 10; t++) do_tick(1'b0, 1'b0, 8'h00, 1'b0);
    check("t3_y9", 32'(sample_out), 32'h29);

    // Eleventh tick of the period with no clk_en.
    do_tick(1'b0, 1'b0, 8'h00, 1'b0);
    check("t4_out",   32'(sample_out),   32'h80);
    check("t4_valid", 32'(sample_valid), 32'h0);
    check("t4_over",  32'(overrun),      32'h1);

    // Capture and period start on the same tick.
    do_tick(1'b0, 1'b1, 8'hA0, 1'b0);
    do_tick(1'b1, 1'b1, 8'hB0, 1'b0);
    check("t5_a0", 32'(sample_out), 32'hA0);
    for (int t = 1; t < 10; t++) do_tick(1'b0, 1'b0, 8'h00, 1'b0);
    check("t5_a9", 32'(sample_out), 32'hA9);
    do_tick(1'b1, 1'b0, 8'h00, 1'b0);
    check("t5_b0", 32'(sample_out), 32'hB0);

    // Reset mid-playback.
    for (int t = 1; t < 4; t++) do_tick(1'b0, 1'b0, 8'h00, 1'b0);
    check("t6_b3", 32'(sample_out), 32'hB3);
    do_reset();
    check("t6_out",   32'(sample_out),   32'h80);
    check("t6_valid", 32'(sample_valid), 32'h0);
    do_tick(1'b1, 1'b0, 8'h00, 1'b0);
    check("t6_under", 32'(underrun), 32'h1);

    // Randomized streams: irregular periods, random captures, occasional reset.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      do_tick($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, 8'h00, 1'b1);
    end

    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
